// File: rtl/spi_master_if.sv
// Byte-side handshake and SPI pin bundle for the spi_master initiator.
// The master modport is the initiator's view; slave is the system/responder side.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, sck, mosi, cs_n
    );

    modport slave (
        output tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, sck, mosi, cs_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, 8-bit frames, with cs_n setup/hold/deselect
// timing and back-to-back bytes inside one cs_n-low burst.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master spi
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_cnt_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BIT_W-1:0]   w_bit_cnt_nxt;
    logic [6:0]         r_tx_shift;
    logic [6:0]         w_tx_shift_nxt;
    logic [7:0]         r_rx_shift;
    logic [7:0]         w_rx_shift_nxt;
    logic               r_sck;
    logic               w_sck_nxt;
    logic               r_mosi;
    logic               w_mosi_nxt;
    logic               r_cs_n;
    logic               w_cs_n_nxt;
    logic [7:0]         r_rx_data;
    logic [7:0]         w_rx_data_nxt;
    logic               r_rx_valid;
    logic               w_rx_valid_nxt;

    logic               w_tick;
    logic               w_last_fall;
    logic               w_tx_ready;
    logic               w_accept;

    assign w_tick      = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_last_fall = (r_state == S_XFER) && w_tick && r_sck && (r_bit_cnt == BIT_W'(7));
    assign w_tx_ready  = !rst && ((r_state == S_IDLE) || w_last_fall);
    assign w_accept    = spi.tx_valid && w_tx_ready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                w_state_nxt = S_SETUP;
            S_SETUP: if (w_tick)                  w_state_nxt = S_XFER;
            S_XFER:  if (w_last_fall && !w_accept) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tick)                  w_state_nxt = S_GAP;
            S_GAP:   if (w_tick)                  w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and shifters
    always_comb begin
        w_div_cnt_nxt  = w_tick ? '0 : r_div_cnt + DIV_W'(1);
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_cnt_nxt = '0;
                w_sck_nxt     = 1'b0;
                w_cs_n_nxt    = 1'b1;
                if (w_accept) begin
                    w_tx_shift_nxt = spi.tx_data[6:0];
                    w_mosi_nxt     = spi.tx_data[7];
                    w_cs_n_nxt     = 1'b0;
                    w_bit_cnt_nxt  = '0;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_sck_nxt      = 1'b1;
                    w_rx_shift_nxt = {r_rx_shift[6:0], spi.miso};
                end
            end
            S_XFER: begin
                if (w_tick) begin
                    w_sck_nxt = !r_sck;
                    if (!r_sck) begin
                        w_rx_shift_nxt = {r_rx_shift[6:0], spi.miso};
                    end else if (r_bit_cnt != BIT_W'(7)) begin
                        w_mosi_nxt     = r_tx_shift[6];
                        w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
                        w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
                    end else begin
                        w_rx_data_nxt  = r_rx_shift;
                        w_rx_valid_nxt = 1'b1;
                        // Burst: the next byte reuses this falling edge as its load point
                        if (w_accept) begin
                            w_tx_shift_nxt = spi.tx_data[6:0];
                            w_mosi_nxt     = spi.tx_data[7];
                            w_bit_cnt_nxt  = '0;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_cs_n_nxt = 1'b1;
                    w_mosi_nxt = 1'b0;
                end
            end
            S_GAP: begin
            end
            default: begin
            end
        endcase
    end

    assign spi.tx_ready = w_tx_ready;
    assign spi.rx_data  = r_rx_data;
    assign spi.rx_valid = r_rx_valid;
    assign spi.sck      = r_sck;
    assign spi.mosi     = r_mosi;
    assign spi.cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 and CLK_DIV=2 instances, loopback/tied miso,
// scoreboard of expected received bytes and their arrival cycle.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_if bus4();
    spi_master_if bus2();

    logic miso_tie4 = 1'b0;
    assign bus4.miso = miso_tie4 ? 1'b1 : bus4.mosi;
    assign bus2.miso = bus2.mosi;

    spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .spi(bus4));
    spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .spi(bus2));

    typedef struct packed {
        logic [7:0]  d;
        int unsigned c;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_errors = 0;

    int unsigned rises4 = 0;
    int unsigned rxv4 = 0;
    int unsigned mosi_ones4 = 0;
    int unsigned cs_rise4 = 0;
    logic [15:0] cap4 = '0;
    logic        prev_sck4 = 1'b0;
    logic        prev_cs4 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling clk edge and observe both DUTs there
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus4.rx_valid) begin
            rxv4++;
            if (q4.size() == 0) check("rx4_unexpected", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                check("rx4_data", 32'(bus4.rx_data), 32'(e.d));
                check("rx4_cycle", cyc, e.c);
            end
        end
        if (bus2.rx_valid) begin
            if (q2.size() == 0) check("rx2_unexpected", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                check("rx2_data", 32'(bus2.rx_data), 32'(e.d));
                check("rx2_cycle", cyc, e.c);
            end
        end
        if (bus4.sck && !prev_sck4) begin
            rises4++;
            cap4 = {cap4[14:0], bus4.mosi};
        end
        if (bus4.mosi) mosi_ones4++;
        if (bus4.cs_n && !prev_cs4) cs_rise4++;
        prev_sck4 = bus4.sck;
        prev_cs4  = bus4.cs_n;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) step();
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (!(bus4.tx_ready && bus4.cs_n) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("idle4_timeout", 32'd0, 32'd1);
    endtask

    // Present a byte to dut4 at a falling edge; returns the accepting clk edge
    task automatic send4(input logic [7:0] d, input logic [7:0] rx_exp, input bit track,
                         output int unsigned acc);
        int n = 0;
        exp_t e;
        bus4.tx_data  = d;
        bus4.tx_valid = 1'b1;
        while (!bus4.tx_ready && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("tx4_timeout", 32'd0, 32'd1);
        acc = cyc + 1;
        if (track) begin
            e.d = rx_exp;
            e.c = acc + 64;
            q4.push_back(e);
        end
        step();
        bus4.tx_valid = 1'b0;
    endtask

    initial begin
        int unsigned a1, a2;
        int unsigned r0, m0, c0, v0;
        exp_t e;

        bus4.tx_data = '0; bus4.tx_valid = 1'b0;
        bus2.tx_data = '0; bus2.tx_valid = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_cs_n", 32'(bus4.cs_n), 32'd1);
        check("rst_sck", 32'(bus4.sck), 32'd0);
        check("rst_mosi", 32'(bus4.mosi), 32'd0);
        check("rst_rx_data", 32'(bus4.rx_data), 32'h00);
        check("rst_rx_valid", 32'(bus4.rx_valid), 32'd0);
        check("rst_tx_ready", 32'(bus4.tx_ready), 32'd0);
        rst = 1'b0;
        step();
        check("idle_tx_ready", 32'(bus4.tx_ready), 32'd1);

        // Loopback A5 with exact edge timing
        r0 = rises4;
        send4(8'hA5, 8'hA5, 1'b1, a1);
        check("a5_cs_low", 32'(bus4.cs_n), 32'd0);
        check("a5_mosi_msb", 32'(bus4.mosi), 32'd1);
        wait_cyc(a1 + 3);
        check("a5_sck_setup", 32'(bus4.sck), 32'd0);
        wait_cyc(a1 + 4);
        check("a5_sck_rise1", 32'(bus4.sck), 32'd1);
        wait_cyc(a1 + 8);
        check("a5_sck_fall1", 32'(bus4.sck), 32'd0);
        wait_cyc(a1 + 67);
        check("a5_cs_hold", 32'(bus4.cs_n), 32'd0);
        wait_cyc(a1 + 68);
        check("a5_cs_high", 32'(bus4.cs_n), 32'd1);
        wait_cyc(a1 + 71);
        check("a5_gap_ready", 32'(bus4.tx_ready), 32'd0);
        wait_cyc(a1 + 72);
        check("a5_idle_ready", 32'(bus4.tx_ready), 32'd1);
        check("a5_mosi_bits", 32'(cap4[7:0]), 32'hA5);
        check("a5_rises", rises4 - r0, 32'd8);

        // miso tied high, transmit zero
        miso_tie4 = 1'b1;
        r0 = rises4; m0 = mosi_ones4; v0 = rxv4;
        send4(8'h00, 8'hFF, 1'b1, a1);
        wait_idle4();
        check("ones_rises", rises4 - r0, 32'd8);
        check("ones_mosi_zero", mosi_ones4 - m0, 32'd0);
        check("ones_rxv", rxv4 - v0, 32'd1);
        miso_tie4 = 1'b0;

        // Burst of two bytes in one cs_n-low window
        r0 = rises4; c0 = cs_rise4;
        send4(8'h3C, 8'h3C, 1'b1, a1);
        send4(8'hC3, 8'hC3, 1'b1, a2);
        check("burst_spacing", a2 - a1, 32'd64);
        wait_idle4();
        check("burst_cs_rises", cs_rise4 - c0, 32'd1);
        check("burst_rises", rises4 - r0, 32'd16);
        check("burst_mosi", 32'(cap4), 32'h3CC3);

        // tx_valid while busy is ignored until the next tx_ready
        r0 = rises4;
        send4(8'h12, 8'h12, 1'b1, a1);
        wait_cyc(a1 + 20);
        check("busy_tx_ready", 32'(bus4.tx_ready), 32'd0);
        bus4.tx_data  = 8'hFF;
        bus4.tx_valid = 1'b1;
        wait_cyc(a1 + 40);
        send4(8'hFF, 8'hFF, 1'b1, a2);
        check("busy_accept_cycle", a2, a1 + 64);
        wait_idle4();
        check("busy_mosi", 32'(cap4), 32'h12FF);
        check("busy_rises", rises4 - r0, 32'd16);

        // Reset mid-transfer aborts without rx_valid
        v0 = rxv4;
        send4(8'h77, 8'h77, 1'b0, a1);
        wait_cyc(a1 + 30);
        rst = 1'b1;
        step();
        check("abort_cs_n", 32'(bus4.cs_n), 32'd1);
        check("abort_sck", 32'(bus4.sck), 32'd0);
        check("abort_mosi", 32'(bus4.mosi), 32'd0);
        check("abort_tx_ready", 32'(bus4.tx_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("abort_ready_after", 32'(bus4.tx_ready), 32'd1);
        repeat (80) step();
        check("abort_no_rxv", rxv4 - v0, 32'd0);
        send4(8'h5A, 8'h5A, 1'b1, a1);
        wait_idle4();
        check("after_abort_mosi", 32'(cap4[7:0]), 32'h5A);

        // CLK_DIV=2 instance, loopback 81
        bus2.tx_data  = 8'h81;
        bus2.tx_valid = 1'b1;
        check("div2_ready", 32'(bus2.tx_ready), 32'd1);
        a1 = cyc + 1;
        e.d = 8'h81;
        e.c = a1 + 32;
        q2.push_back(e);
        step();
        bus2.tx_valid = 1'b0;
        wait_cyc(a1 + 1);
        check("div2_sck_setup", 32'(bus2.sck), 32'd0);
        wait_cyc(a1 + 2);
        check("div2_sck_rise", 32'(bus2.sck), 32'd1);
        wait_cyc(a1 + 4);
        check("div2_sck_fall", 32'(bus2.sck), 32'd0);
        wait_cyc(a1 + 6);
        check("div2_sck_rise2", 32'(bus2.sck), 32'd1);
        wait_cyc(a1 + 48);

        check("q4_drained", q4.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
